// File: rtl/dfr_pkg.sv
// Shared register map, bit positions and response codes for the DFR capture core.
package dfr_pkg;

    localparam logic [8:0] REG_CTRL         = 9'h000;
    localparam logic [8:0] REG_CMD          = 9'h004;
    localparam logic [8:0] REG_SAMPLE_COUNT = 9'h008;
    localparam logic [8:0] REG_NODE_INDEX   = 9'h00C;
    localparam logic [8:0] REG_STATUS       = 9'h010;
    localparam logic [8:0] REG_NODE_BASE    = 9'h100;

    localparam int CTRL_RUN_BIT       = 0;
    localparam int CMD_CLEAR_BIT      = 0;
    localparam int STATUS_RUN_BIT     = 0;
    localparam int STATUS_WRAPPED_BIT = 1;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/dfr_axi_regs.sv
// AXI4-Lite slave handshake, CTRL register and read decode for the DFR core.
module dfr_axi_regs
    import dfr_pkg::*;
#(
    parameter int AW = 9,
    parameter int DW = 32,
    parameter int VN = 10
) (
    input  logic          clk,
    input  logic          srst,
    input  logic [AW-1:0] S_AXI_AWADDR,
    input  logic          S_AXI_AWVALID,
    output logic          S_AXI_AWREADY,
    input  logic [DW-1:0] S_AXI_WDATA,
    input  logic          S_AXI_WVALID,
    output logic          S_AXI_WREADY,
    output logic [1:0]    S_AXI_BRESP,
    output logic          S_AXI_BVALID,
    input  logic          S_AXI_BREADY,
    input  logic [AW-1:0] S_AXI_ARADDR,
    input  logic          S_AXI_ARVALID,
    output logic          S_AXI_ARREADY,
    output logic [DW-1:0] S_AXI_RDATA,
    output logic [1:0]    S_AXI_RRESP,
    output logic          S_AXI_RVALID,
    input  logic          S_AXI_RREADY,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          ctrl_run,
    input  logic [DW-1:0] sample_count,
    input  logic [DW-1:0] node_index,
    input  logic          wrapped,
    output logic [5:0]    node_sel,
    input  logic [DW-1:0] node_rd_data
);

    localparam int NODE_WORD = int'(REG_NODE_BASE >> 2);

    logic          awready_reg, bvalid_reg, arready_reg, rvalid_reg;
    logic [DW-1:0] ctrl_reg, rdata_reg, rd_mux;
    logic [AW-3:0] rd_word;
    logic          rd_en;
    logic          unused_bits;

    assign wr_en    = awready_reg & S_AXI_AWVALID & S_AXI_WVALID;
    assign wr_addr  = S_AXI_AWADDR;
    assign wr_data  = S_AXI_WDATA;
    assign rd_en    = arready_reg & S_AXI_ARVALID;
    assign rd_word  = S_AXI_ARADDR[AW-1:2];
    assign ctrl_run = ctrl_reg[CTRL_RUN_BIT];

    assign S_AXI_AWREADY = awready_reg;
    assign S_AXI_WREADY  = awready_reg;
    assign S_AXI_BVALID  = bvalid_reg;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_ARREADY = arready_reg;
    assign S_AXI_RVALID  = rvalid_reg;
    assign S_AXI_RDATA   = rdata_reg;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign unused_bits   = ^S_AXI_ARADDR[1:0];

    always_comb begin
        rd_mux   = '0;
        node_sel = '0;
        if (rd_word == (AW-2)'(REG_CTRL >> 2)) begin
            rd_mux = ctrl_reg;
        end else if (rd_word == (AW-2)'(REG_SAMPLE_COUNT >> 2)) begin
            rd_mux = sample_count;
        end else if (rd_word == (AW-2)'(REG_NODE_INDEX >> 2)) begin
            rd_mux = node_index;
        end else if (rd_word == (AW-2)'(REG_STATUS >> 2)) begin
            rd_mux[STATUS_RUN_BIT]     = ctrl_run;
            rd_mux[STATUS_WRAPPED_BIT] = wrapped;
        end else if (int'(rd_word) >= NODE_WORD && int'(rd_word) < NODE_WORD + VN) begin
            node_sel = 6'(int'(rd_word) - NODE_WORD);
            rd_mux   = node_rd_data;
        end
    end

    // Ready pulses last one cycle; the following edge is the commit edge.
    always_ff @(posedge clk) begin
        if (srst) begin
            awready_reg <= 1'b0;
            bvalid_reg  <= 1'b0;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rdata_reg   <= '0;
            ctrl_reg    <= '0;
        end else begin
            awready_reg <= !awready_reg && !bvalid_reg && S_AXI_AWVALID && S_AXI_WVALID;
            if (wr_en) begin
                bvalid_reg <= 1'b1;
            end else if (S_AXI_BREADY) begin
                bvalid_reg <= 1'b0;
            end
            if (wr_en && S_AXI_AWADDR[AW-1:2] == (AW-2)'(REG_CTRL >> 2)) begin
                ctrl_reg <= S_AXI_WDATA;
            end

            arready_reg <= !arready_reg && !rvalid_reg && S_AXI_ARVALID;
            if (rd_en) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= rd_mux;
            end else if (S_AXI_RREADY) begin
                rvalid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dfr_core.sv
// DFR capture core: ring of node registers fed by the reservoir stream, with
// sample counter and wrap flag, controlled through an AXI4-Lite window.
module dfr_core
    import dfr_pkg::*;
#(
    parameter int C_S_AXI_ACLK_FREQ_HZ         = 100000000,
    parameter int C_S_AXI_DATA_WIDTH           = 32,
    parameter int C_S_AXI_ADDR_WIDTH           = 9,
    parameter int VIRTUAL_NODES                = 10,
    parameter int RESERVOIR_DATA_WIDTH         = 32,
    parameter int RESERVOIR_HISTORY_ADDR_WIDTH = 20
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [RESERVOIR_DATA_WIDTH-1:0] reservoir_data_in
);

    localparam int AW     = C_S_AXI_ADDR_WIDTH;
    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int HW     = RESERVOIR_HISTORY_ADDR_WIDTH;
    localparam int NIDX_W = (VIRTUAL_NODES > 1) ? $clog2(VIRTUAL_NODES) : 1;

    logic                            wr_en, ctrl_run, cmd_clear;
    logic [AW-1:0]                   wr_addr;
    logic [DW-1:0]                   wr_data, node_rd_data;
    logic [5:0]                      node_sel;
    logic [NIDX_W-1:0]               node_idx_reg;
    logic [HW-1:0]                   sample_count_reg;
    logic                            wrapped_reg;
    logic [RESERVOIR_DATA_WIDTH-1:0] node_reg [VIRTUAL_NODES];
    logic                            unused_bits;

    assign cmd_clear = wr_en && (wr_addr[AW-1:2] == (AW-2)'(REG_CMD >> 2))
                       && wr_data[CMD_CLEAR_BIT];
    assign unused_bits = ^{S_AXI_WSTRB, wr_addr[1:0], wr_data[DW-1:1],
                           32'(C_S_AXI_ACLK_FREQ_HZ)};

    // Clear takes priority over a capture on the same edge.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET || cmd_clear) begin
            node_idx_reg     <= '0;
            sample_count_reg <= '0;
            wrapped_reg      <= 1'b0;
        end else if (ctrl_run) begin
            if (node_idx_reg == NIDX_W'(VIRTUAL_NODES - 1)) begin
                node_idx_reg <= '0;
                wrapped_reg  <= 1'b1;
            end else begin
                node_idx_reg <= node_idx_reg + NIDX_W'(1);
            end
            if (sample_count_reg != '1) begin
                sample_count_reg <= sample_count_reg + HW'(1);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < VIRTUAL_NODES; gi++) begin : g_node
            always_ff @(posedge S_AXI_ACLK) begin
                if (S_AXI_ARESET || cmd_clear) begin
                    node_reg[gi] <= '0;
                end else if (ctrl_run && node_idx_reg == NIDX_W'(gi)) begin
                    node_reg[gi] <= reservoir_data_in;
                end
            end
        end
    endgenerate

    always_comb begin
        node_rd_data = '0;
        for (int i = 0; i < VIRTUAL_NODES; i++) begin
            if (node_sel == 6'(i)) begin
                node_rd_data = DW'(node_reg[i]);
            end
        end
    end

    dfr_axi_regs #(
        .AW(AW),
        .DW(DW),
        .VN(VIRTUAL_NODES)
    ) u_regs (
        .clk          (S_AXI_ACLK),
        .srst         (S_AXI_ARESET),
        .S_AXI_AWADDR (S_AXI_AWADDR),
        .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA  (S_AXI_WDATA),
        .S_AXI_WVALID (S_AXI_WVALID),
        .S_AXI_WREADY (S_AXI_WREADY),
        .S_AXI_BRESP  (S_AXI_BRESP),
        .S_AXI_BVALID (S_AXI_BVALID),
        .S_AXI_BREADY (S_AXI_BREADY),
        .S_AXI_ARADDR (S_AXI_ARADDR),
        .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA  (S_AXI_RDATA),
        .S_AXI_RRESP  (S_AXI_RRESP),
        .S_AXI_RVALID (S_AXI_RVALID),
        .S_AXI_RREADY (S_AXI_RREADY),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .ctrl_run     (ctrl_run),
        .sample_count (DW'(sample_count_reg)),
        .node_index   (DW'(node_idx_reg)),
        .wrapped      (wrapped_reg),
        .node_sel     (node_sel),
        .node_rd_data (node_rd_data)
    );

endmodule

// File: tb/tb_dfr_core.sv
// Self-checking bench for dfr_core: reset table, handshake sequences, ramp
// capture and randomized traffic against a sample-list reference model.
module tb_dfr_core;

    localparam int VN = 10;
    localparam logic [31:0] STEP = 32'h028F5C29;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata, din;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int total = 0;
    int bad   = 0;
    int din_mode = 0;

    always #5 clk = ~clk;

    dfr_core #(.VIRTUAL_NODES(VN)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .reservoir_data_in(din)
    );

    // Reference model: a count of captured samples plus the last sample per slot.
    logic [31:0] m_ctrl;
    int          m_total;
    logic [31:0] m_nodes [VN];
    bit          m_commit;

    always @(posedge clk) begin
        if (rst) begin
            m_ctrl  = 0;
            m_total = 0;
            for (int i = 0; i < VN; i++) m_nodes[i] = 0;
        end else begin
            m_commit = awready && awvalid && wvalid;
            if (m_commit && awaddr[8:2] == 7'd1 && wdata[0]) begin
                m_total = 0;
                for (int i = 0; i < VN; i++) m_nodes[i] = 0;
            end else if (m_ctrl[0]) begin
                m_nodes[m_total % VN] = din;
                m_total++;
            end
            if (m_commit && awaddr[8:2] == 7'd0) m_ctrl = wdata;
        end
    end

    always @(negedge clk) begin
        if (din_mode == 1) din = din + STEP;
        else if (din_mode == 2) din = $urandom;
    end

    function automatic logic [31:0] model_read(logic [8:0] a);
        int w;
        w = int'(a[8:2]);
        if (w == 0) return m_ctrl;
        if (w == 2) return (m_total > 1048575) ? 32'hFFFFF : 32'(m_total);
        if (w == 3) return 32'(m_total % VN);
        if (w == 4) return {30'd0, m_total >= VN, m_ctrl[0]};
        if (w >= 64 && w < 64 + VN) return m_nodes[w - 64];
        return 32'h0;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic wait_for(int which, string name);
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            case (which)
                0: seen = awready;
                1: seen = bvalid;
                2: seen = arready;
                default: seen = rvalid;
            endcase
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL timeout %s: got 0 expected 1", name);
        end
    endtask

    task automatic axi_write(logic [8:0] a, logic [31:0] d);
        awaddr = a; wdata = d; wstrb = 4'h0; awvalid = 1; wvalid = 1;
        wait_for(0, "awready");
        chk("wready_with_aw", 32'(wready), 32'd1);
        wait_for(1, "bvalid");
        awvalid = 0; wvalid = 0;
        chk($sformatf("bresp_%h", a), 32'(bresp), 32'd0);
        bready = 1;
        @(negedge clk);
        bready = 0;
    endtask

    task automatic rd_chk(string name, logic [8:0] a, output logic [31:0] d);
        logic [31:0] e;
        araddr = a; arvalid = 1;
        wait_for(2, "arready");
        e = model_read(a);
        wait_for(3, "rvalid");
        arvalid = 0;
        d = rdata;
        chk($sformatf("%s_%h", name, a), rdata, e);
        if (rresp !== 2'b00) chk("rresp", 32'(rresp), 32'd0);
        rready = 1;
        @(negedge clk);
        rready = 0;
    endtask

    typedef struct { logic [8:0] addr; logic [31:0] exp; } vec_t;
    vec_t        tbl [9];
    logic [31:0] d;
    int          r;

    initial begin
        rst = 1; awaddr = 0; araddr = 0; awvalid = 0; wvalid = 0; bready = 0;
        arvalid = 0; rready = 0; wdata = 0; wstrb = 0; din = 0;
        repeat (3) @(negedge clk);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_flags", 32'({awready, wready, bvalid, bresp, arready, rvalid, rresp}), 32'h0);
        rst = 0;
        @(negedge clk);

        tbl[0] = '{9'h000, 32'h0}; tbl[1] = '{9'h004, 32'h0}; tbl[2] = '{9'h008, 32'h0};
        tbl[3] = '{9'h00C, 32'h0}; tbl[4] = '{9'h010, 32'h0}; tbl[5] = '{9'h100, 32'h0};
        tbl[6] = '{9'h124, 32'h0}; tbl[7] = '{9'h128, 32'h0}; tbl[8] = '{9'h1FC, 32'h0};
        for (int i = 0; i < 9; i++) begin
            rd_chk("reset_rd", tbl[i].addr, d);
            chk($sformatf("reset_tbl_%h", tbl[i].addr), d, tbl[i].exp);
        end

        // Write with BREADY held off; a second write presented meanwhile must stall.
        awaddr = 9'h000; wdata = 32'hDEADBEEF; wstrb = 4'h0; awvalid = 1; wvalid = 1;
        wait_for(0, "aw_first");
        wait_for(1, "bvalid_first");
        wdata = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bvalid_hold", 32'(bvalid), 32'd1);
            chk("no_second_aw", 32'(awready), 32'd0);
        end
        awvalid = 0; wvalid = 0; bready = 1;
        @(negedge clk);
        bready = 0;
        chk("bvalid_drop", 32'(bvalid), 32'd0);
        rd_chk("ctrl", 9'h000, d);
        chk("ctrl_deadbeef", d, 32'hDEADBEEF);
        axi_write(9'h000, 32'h0);
        axi_write(9'h004, 32'h1);

        // Ramp capture over several frames.
        din = 0; din_mode = 1;
        axi_write(9'h000, 32'h1);
        repeat (100) @(negedge clk);
        axi_write(9'h000, 32'h0);
        din_mode = 0;
        for (int a = 2; a <= 4; a++) rd_chk("ramp", 9'(a * 4), d);
        for (int n = 0; n < VN; n++) rd_chk("ramp_node", 9'(256 + 4 * n), d);

        // Clear while running: clear wins on its edge, capture resumes after.
        din_mode = 2;
        axi_write(9'h000, 32'h1);
        repeat (7) @(negedge clk);
        axi_write(9'h004, 32'h1);
        rd_chk("clr_cnt", 9'h008, d);
        axi_write(9'h000, 32'h0);
        for (int a = 2; a <= 4; a++) rd_chk("clr", 9'(a * 4), d);
        for (int n = 0; n < VN; n++) rd_chk("clr_node", 9'(256 + 4 * n), d);

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r < 2) axi_write(9'h000, $urandom);
            else if (r == 2) axi_write(9'h004, $urandom);
            else if (r == 3) axi_write(9'($urandom_range(2, 127) * 4), $urandom);
            else rd_chk("rand", 9'($urandom_range(0, 511)), d);
        end

        // Reset in the middle of a pending read response.
        axi_write(9'h000, 32'h5);
        araddr = 9'h000; arvalid = 1;
        wait_for(2, "arready_rst");
        wait_for(3, "rvalid_rst");
        arvalid = 0; rst = 1;
        @(negedge clk);
        chk("rst_mid_rvalid", 32'(rvalid), 32'd0);
        chk("rst_mid_arready", 32'(arready), 32'd0);
        rst = 0;
        @(negedge clk);
        rd_chk("post_rst_ctrl", 9'h000, d);
        chk("post_rst_ctrl_zero", d, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
